dvi_serializer: RTL and testbench
=================================

DVI_SERIALIZER -- requirements
Module: dvi_serializer

Interface
REQ-001 SHALL have port clk, input, 1, 125 MHz shift clock (5x pixel clock), sole clock of the block.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port locked, input, 1, PLL lock, asynchronous to clk.
REQ-004 SHALL have ports in_red, in_green, in_blue, input, 10 each, TMDS-encoded channel words.
REQ-005 SHALL have port in_valid, input, 1, words carry pixel data; low selects the blanking control word.
REQ-006 SHALL have ports out_red, out_green, out_blue, out_clock, output, 2 each, bit pairs for DDR output cells; bit0 = first-half bit.
REQ-007 SHALL have port load, output, 1, high during the cycle in which input words are sampled.
REQ-008 SHALL have port active, output, 1, serializer running.
REQ-009 SHALL have parameter SETTLE_CYCLES, default 16, clk cycles of stable lock before RUN.

Function
REQ-010 SHALL synchronize locked through two clk flops (lock_s); no other logic uses locked directly.
REQ-011 SHALL implement states IDLE, SETTLE, RUN.
REQ-012 IDLE -> SETTLE when lock_s=1; settle counter cleared on entry.
REQ-013 SETTLE: counter increments each cycle; -> RUN on the cycle after the counter reaches SETTLE_CYCLES-1; -> IDLE if lock_s=0.
REQ-014 RUN -> IDLE on the edge after lock_s=0, from any phase; a partial word is discarded.
REQ-015 SHALL keep a 3-bit phase counter 0..4, wrapping 4 -> 0, advancing only in RUN; phase=0 in the first RUN cycle; held at 0 outside RUN.
REQ-016 load SHALL be registered, high exactly during RUN cycles with phase=4, giving one load per 5 cycles.
REQ-017 At the edge ending a load cycle, the shift registers SHALL capture in_red/in_green/in_blue when in_valid=1, else 10'b1101010100 on all three channels.
REQ-018 The out_clock shift register SHALL capture 10'b0000011111 at every load edge.
REQ-019 On all other RUN edges, each shift register SHALL shift right by 2, zero-filling from the top.
REQ-020 out_* SHALL equal bits [1:0] of their shift registers; word bits [1:0],[3:2],[5:4],[7:6],[9:8] appear at phases 0..4 after capture.
REQ-021 Latency from the load-cycle sample edge to word[1:0] at out_*: 0 cycles; a full word is emitted in the 5 cycles following capture.
REQ-022 From RUN entry until the first capture, out_* SHALL be 2'b00.
REQ-023 On any transition to IDLE, shift registers, phase, and load SHALL clear on that edge; active SHALL drop on that edge.
REQ-024 active SHALL be registered, high exactly while the state is RUN.
REQ-025 Inputs are sampled only at load edges; their value on other cycles SHALL have no effect.

Reset
REQ-026 While reset is high: state IDLE, lock sync flops 0, settle counter 0, phase 0, shift registers 0, every out_* 2'b00, load 0, active 0.
REQ-027 After reset deasserts with locked=1, RUN SHALL be entered SETTLE_CYCLES+3 edges later (2 sync, 1 IDLE->SETTLE).
REQ-028 Reset asserted mid-RUN SHALL apply REQ-026 immediately, without waiting for a clk edge.

Verification
REQ-029 locked=1 held, reset released -> active rises after 19 edges (SETTLE_CYCLES=16); load pulses every 5th cycle starting at the 5th RUN cycle.
REQ-030 in_valid=1, in_red=10'b1011001110 at load -> out_red reads 2'b10, 2'b11, 2'b00, 2'b11, 2'b10 over the next 5 cycles; out_clock reads 2'b11, 2'b11, 2'b01, 2'b00, 2'b00.
REQ-031 in_valid=0 at load with arbitrary inputs -> all three data channels emit 1101010100 (pairs 00, 01, 01, 01, 11).
REQ-032 locked dropped during phase 2 of RUN -> active low and out_* 2'b00 from the 3rd edge; locked reasserted -> SETTLE restarts from 0.
REQ-033 locked glitching low for 1 cycle during SETTLE -> return to IDLE; RUN entered only after SETTLE_CYCLES uninterrupted lock_s cycles.
REQ-034 reset pulsed asynchronously mid-word -> all outputs 0 before the next clk edge; full reset-release sequence of REQ-029 repeats.

Source files
------------

// File: rtl/dvi_serializer.sv
// DVI/TMDS 10:2 serializer for three data channels plus the TMDS clock channel.
// Waits for a settled PLL lock, then emits one 10-bit word per channel every 5 shift clocks.
module dvi_serializer #(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked,
    input  logic [9:0] in_red,
    input  logic [9:0] in_green,
    input  logic [9:0] in_blue,
    input  logic       in_valid,
    output logic [1:0] out_red,
    output logic [1:0] out_green,
    output logic [1:0] out_blue,
    output logic [1:0] out_clock,
    output logic       load,
    output logic       active
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;

    localparam logic [9:0] CTRL_WORD = 10'b1101010100;
    localparam logic [9:0] CLK_WORD  = 10'b0000011111;

    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    logic          lock_m;
    logic          lock_s;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] settle_cnt;
    logic [2:0]    phase;
    logic [9:0]    sr_red;
    logic [9:0]    sr_green;
    logic [9:0]    sr_blue;
    logic [9:0]    sr_clock;
    logic          run_next;
    logic          stay_run;

    // locked comes from the PLL domain; nothing else may look at it directly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= locked;
            lock_s <= lock_m;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (lock_s)
                    state_nxt = SETTLE;
            end
            SETTLE: begin
                if (!lock_s)
                    state_nxt = IDLE;
                else if (settle_cnt == SETTLE_LAST)
                    state_nxt = RUN;
            end
            RUN: begin
                if (!lock_s)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Held at zero outside SETTLE, so it is already cleared when SETTLE is entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            settle_cnt <= '0;
        else if (state != SETTLE)
            settle_cnt <= '0;
        else
            settle_cnt <= settle_cnt + 1'b1;
    end

    assign run_next = (state_nxt == RUN);
    assign stay_run = (state == RUN) && run_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            active <= 1'b0;
        else
            active <= run_next;
    end

    // Entering RUN and leaving it both clear the datapath; only a continuing RUN advances it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
            load  <= 1'b0;
        end else if (!stay_run) begin
            phase <= '0;
            load  <= 1'b0;
        end else begin
            phase <= (phase == 3'd4) ? 3'd0 : phase + 3'd1;
            load  <= (phase == 3'd3);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_red   <= '0;
            sr_green <= '0;
            sr_blue  <= '0;
            sr_clock <= '0;
        end else if (!stay_run) begin
            sr_red   <= '0;
            sr_green <= '0;
            sr_blue  <= '0;
            sr_clock <= '0;
        end else if (load) begin
            sr_red   <= in_valid ? in_red   : CTRL_WORD;
            sr_green <= in_valid ? in_green : CTRL_WORD;
            sr_blue  <= in_valid ? in_blue  : CTRL_WORD;
            sr_clock <= CLK_WORD;
        end else begin
            sr_red   <= {2'b00, sr_red[9:2]};
            sr_green <= {2'b00, sr_green[9:2]};
            sr_blue  <= {2'b00, sr_blue[9:2]};
            sr_clock <= {2'b00, sr_clock[9:2]};
        end
    end

    assign out_red   = sr_red[1:0];
    assign out_green = sr_green[1:0];
    assign out_blue  = sr_blue[1:0];
    assign out_clock = sr_clock[1:0];

endmodule

// File: tb/tb_dvi_serializer.sv
// Bench for dvi_serializer: word table, lock/reset corner sequences and a random soak
// against a timeline model built from lock-streak length and RUN cycle count.
module tb_dvi_serializer;

    localparam int SETTLE = 16;
    localparam logic [9:0] CTRL = 10'b1101010100;
    localparam logic [9:0] CLKW = 10'b0000011111;

    logic       clk = 1'b0;
    logic       reset;
    logic       locked;
    logic [9:0] in_red, in_green, in_blue;
    logic       in_valid;
    logic [1:0] out_red, out_green, out_blue, out_clock;
    logic       load, active;

    int n_cmp = 0;
    int n_bad = 0;

    // reference timeline
    bit         m_ls1, m_ls2, m_run, m_have;
    int         m_streak, m_k;
    logic [9:0] m_wr, m_wg, m_wb, m_wc;

    typedef struct {
        logic       valid;
        logic [9:0] r, g, b;
        logic [9:0] er, eg, eb;
    } vec_t;
    vec_t tbl[6];

    dvi_serializer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset(reset), .locked(locked),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .in_valid(in_valid),
        .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
        .out_clock(out_clock), .load(load), .active(active)
    );

    always #4 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ls1 = 0; m_ls2 = 0; m_run = 0; m_have = 0;
        m_streak = 0; m_k = 0;
        m_wr = '0; m_wg = '0; m_wb = '0; m_wc = '0;
    endtask

    function automatic logic [1:0] pair(input logic [9:0] w);
        if (!m_have) return 2'b00;
        return 2'(w >> (2 * (m_k % 5)));
    endfunction

    task automatic check_model();
        logic [9:0] exp, act;
        exp = {m_run, m_run && (m_k % 5 == 4), pair(m_wr), pair(m_wg), pair(m_wb), pair(m_wc)};
        act = {active, load, out_red, out_green, out_blue, out_clock};
        check("cycle", 32'(act), 32'(exp));
    endtask

    task automatic step();
        bit         p_ls2, was_run;
        logic       p_lock, p_v;
        logic [9:0] p_r, p_g, p_b;
        p_lock = locked; p_v = in_valid; p_r = in_red; p_g = in_green; p_b = in_blue;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            p_ls2 = m_ls2;
            m_ls2 = m_ls1;
            m_ls1 = p_lock;
            if (p_ls2) begin
                if (m_streak < 1000000) m_streak++;
            end else begin
                m_streak = 0;
            end
            was_run = m_run;
            m_run = (m_streak >= SETTLE + 1);
            if (m_run && was_run) begin
                if (m_k % 5 == 4) begin
                    m_have = 1;
                    m_wr = p_v ? p_r : CTRL;
                    m_wg = p_v ? p_g : CTRL;
                    m_wb = p_v ? p_b : CTRL;
                    m_wc = CLKW;
                end
                m_k++;
            end else begin
                m_k = 0;
                m_have = 0;
            end
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic rand_inputs();
        in_red = 10'($urandom); in_green = 10'($urandom); in_blue = 10'($urandom);
        in_valid = 1'($urandom);
    endtask

    task automatic wait_active(input string name, input int exp_edges);
        int n;
        n = 0;
        while (!active && n < 100) begin
            step();
            n++;
        end
        check(name, 32'(n), 32'(exp_edges));
    endtask

    initial begin
        logic [9:0] gr, gg, gb, gc;
        logic [1:0] p0r[5], p0c[5];
        logic [1:0] er[5], ec[5];
        int n, drop;

        tbl[0] = '{1'b1, 10'b1011001110, 10'h3FF, 10'h000, 10'b1011001110, 10'h3FF, 10'h000};
        tbl[1] = '{1'b0, 10'h2A5, 10'h15A, 10'h3C3, CTRL, CTRL, CTRL};
        tbl[2] = '{1'b1, 10'h155, 10'h2AA, 10'h001, 10'h155, 10'h2AA, 10'h001};
        tbl[3] = '{1'b1, 10'h200, 10'h0F0, 10'h30F, 10'h200, 10'h0F0, 10'h30F};
        tbl[4] = '{1'b0, 10'b1011001110, 10'h3FF, 10'h000, CTRL, CTRL, CTRL};
        tbl[5] = '{1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
        er = '{2'b10, 2'b11, 2'b00, 2'b11, 2'b10};
        ec = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00};

        reset = 1'b1; locked = 1'b0;
        in_red = '0; in_green = '0; in_blue = '0; in_valid = 1'b0;
        model_reset();
        #3;
        check("reset_state", 32'({active, load, out_red, out_green, out_blue, out_clock}), 32'd0);
        @(negedge clk);
        step();
        step();

        // release with lock held: RUN after SETTLE+3 edges, first load on 5th RUN cycle
        locked = 1'b1;
        reset = 1'b0;
        wait_active("lock_to_run", SETTLE + 3);
        n = 1;
        while (!load && n < 20) begin
            step();
            n++;
        end
        check("first_load", 32'(n), 32'd5);

        // word table: inputs set in the load cycle, garbage on every other cycle
        for (int i = 0; i < 6; i++) begin
            in_valid = tbl[i].valid;
            in_red = tbl[i].r; in_green = tbl[i].g; in_blue = tbl[i].b;
            gr = '0; gg = '0; gb = '0; gc = '0;
            for (int j = 0; j < 5; j++) begin
                step();
                gr[2*j +: 2] = out_red;
                gg[2*j +: 2] = out_green;
                gb[2*j +: 2] = out_blue;
                gc[2*j +: 2] = out_clock;
                if (i == 0) begin
                    p0r[j] = out_red;
                    p0c[j] = out_clock;
                end
                if (j < 4) rand_inputs();
            end
            check("word_red", 32'(gr), 32'(tbl[i].er));
            check("word_green", 32'(gg), 32'(tbl[i].eg));
            check("word_blue", 32'(gb), 32'(tbl[i].eb));
            check("word_clock", 32'(gc), 32'(CLKW));
        end
        for (int j = 0; j < 5; j++) begin
            check("pair_red", 32'(p0r[j]), 32'(er[j]));
            check("pair_clock", 32'(p0c[j]), 32'(ec[j]));
        end

        // lock lost in phase 2: active still high for two edges, gone on the third
        n = 0;
        while (!(m_run && m_k % 5 == 2) && n < 20) begin
            step();
            n++;
        end
        check("find_phase2", 32'(n < 20), 32'd1);
        locked = 1'b0;
        step();
        check("drop_edge1", 32'(active), 32'd1);
        step();
        check("drop_edge2", 32'(active), 32'd1);
        step();
        check("drop_edge3", 32'({active, load, out_red, out_green, out_blue, out_clock}), 32'd0);
        step();
        step();
        locked = 1'b1;
        wait_active("relock", SETTLE + 3);
        for (int j = 0; j < 12; j++) begin
            rand_inputs();
            step();
        end

        // one-cycle glitch inside SETTLE restarts the whole settle window
        locked = 1'b0;
        for (int j = 0; j < 5; j++) step();
        locked = 1'b1;
        for (int j = 0; j < 8; j++) step();
        locked = 1'b0;
        step();
        locked = 1'b1;
        wait_active("glitch_relock", SETTLE + 3);

        // asynchronous reset in the middle of a word
        n = 0;
        while (!(m_k >= 7 && m_k % 5 == 2) && n < 20) begin
            rand_inputs();
            step();
            n++;
        end
        check("find_midword", 32'(n < 20), 32'd1);
        check("midword_nonzero", 32'(active), 32'd1);
        #1 reset = 1'b1;
        model_reset();
        #1;
        check("async_reset", 32'({active, load, out_red, out_green, out_blue, out_clock}), 32'd0);
        step();
        step();
        reset = 1'b0;
        wait_active("reset_relock", SETTLE + 3);

        // random soak with occasional lock dropouts
        drop = 0;
        for (int c = 0; c < 1500; c++) begin
            rand_inputs();
            if (drop > 0) begin
                drop--;
            end else if ($urandom_range(149, 0) == 0) begin
                drop = $urandom_range(6, 1);
            end
            locked = (drop == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
